// File: rtl/ccff_bitstream_loader.sv
// Serializes host bitstream words MSB-first into a ccff configuration chain and
// accumulates a CRC-16 over the previous chain contents returned on ccff_tail.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [15:0]       crc_out
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int SC_W      = $clog2(WORD_W + 1);

  localparam logic [SC_W-1:0]  FULL_M1   = SC_W'(WORD_W - 1);
  localparam logic [SC_W-1:0]  LAST_M1   = SC_W'(LAST_BITS - 1);
  localparam logic [CNT_W-1:0] NWORDS_C  = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_hbuf;
  logic              r_hbuf_full;
  logic              r_hbuf_last;
  logic [WORD_W-1:0] r_sreg;
  logic [SC_W-1:0]   r_sreg_cnt;
  logic [CNT_W-1:0]  r_words;
  logic              r_head;
  logic              r_shift_en;
  logic [CNT_W-1:0]  r_bit_count;
  logic [15:0]       r_crc;
  logic              w_ready;
  logic              w_accept;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign w_ready  = (r_state == S_LOAD) && !r_hbuf_full && (r_words < NWORDS_C);
  assign w_accept = w_ready && cfg_valid;

  // r_sreg_cnt counts bits still in r_sreg; the bit on r_head has already left it,
  // so an empty r_sreg can reload from r_hbuf without a bubble.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state     <= S_IDLE;
      r_hbuf_full <= 1'b0;
      r_hbuf_last <= 1'b0;
      r_sreg_cnt  <= '0;
      r_words     <= '0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_bit_count <= '0;
      r_crc       <= 16'hFFFF;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_hbuf_full <= 1'b0;
      r_sreg_cnt  <= '0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
    end else begin
      if (r_shift_en) begin
        r_bit_count <= r_bit_count + 1'b1;
        r_crc       <= crc16_step(r_crc, ccff_tail);
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          r_head     <= 1'b0;
          r_shift_en <= 1'b0;
          if (start) begin
            r_state     <= S_LOAD;
            r_bit_count <= '0;
            r_crc       <= 16'hFFFF;
            r_hbuf_full <= 1'b0;
            r_sreg_cnt  <= '0;
            r_words     <= '0;
          end
        end
        S_LOAD: begin
          if (r_shift_en && (r_bit_count == FINAL_CNT)) begin
            r_state    <= S_DONE;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
          end else begin
            if (r_sreg_cnt != '0) begin
              r_head     <= r_sreg[WORD_W-1];
              r_sreg     <= r_sreg << 1;
              r_sreg_cnt <= r_sreg_cnt - 1'b1;
              r_shift_en <= 1'b1;
            end else if (r_hbuf_full) begin
              r_head      <= r_hbuf[WORD_W-1];
              r_sreg      <= r_hbuf << 1;
              r_sreg_cnt  <= r_hbuf_last ? LAST_M1 : FULL_M1;
              r_shift_en  <= 1'b1;
              r_hbuf_full <= 1'b0;
            end else begin
              r_head     <= 1'b0;
              r_shift_en <= 1'b0;
            end
            if (w_accept) begin
              r_hbuf      <= cfg_data;
              r_hbuf_full <= 1'b1;
              r_hbuf_last <= (r_words == LAST_IDX);
              r_words     <= r_words + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready     = w_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = (r_state == S_LOAD);
  assign done          = (r_state == S_DONE);
  assign bit_count     = r_bit_count;
  assign crc_out       = r_crc;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (16-bit and 12-bit chains) share
// stimulus and are compared every cycle against a word/bit-level reference model.
module tb_ccff_bitstream_loader;
  localparam int WW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, valid, tail;
  logic [7:0] data;
  logic       rdy0, head0, sh0, busy0, done0;
  logic       rdy1, head1, sh1, busy1, done1;
  logic [15:0] bc0, crc0, bc1, crc1;

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(WW), .CNT_W(16)) u_dut16 (
    .prog_clk(clk), .pReset(rst), .start(start), .abort(abort),
    .cfg_data(data), .cfg_valid(valid), .cfg_ready(rdy0),
    .ccff_head(head0), .ccff_shift_en(sh0), .ccff_tail(tail),
    .busy(busy0), .done(done0), .bit_count(bc0), .crc_out(crc0));

  ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(WW), .CNT_W(16)) u_dut12 (
    .prog_clk(clk), .pReset(rst), .start(start), .abort(abort),
    .cfg_data(data), .cfg_valid(valid), .cfg_ready(rdy1),
    .ccff_head(head1), .ccff_shift_en(sh1), .ccff_tail(tail),
    .busy(busy1), .done(done1), .bit_count(bc1), .crc_out(crc1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: state 0=idle 1=load 2=done; one pending word plus the word being emitted.
  int         m_st[2], m_cnt[2], m_words[2], m_hn[2], m_cn[2], m_cp[2];
  logic [15:0] m_crc[2];
  bit         m_sh[2], m_head[2], m_hv[2];
  logic [7:0] m_hd[2], m_cd[2];

  function automatic int f_cl(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  function automatic int f_nw(input int i);
    return (f_cl(i) + WW - 1) / WW;
  endfunction

  function automatic bit m_ready(input int i);
    return (m_st[i] == 1) && !m_hv[i] && (m_words[i] < f_nw(i));
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  task automatic model_edge(input int i);
    bit acc;
    int lastn;
    lastn = f_cl(i) - (f_nw(i) - 1) * WW;
    acc = valid && m_ready(i);
    if (rst) begin
      m_st[i] = 0; m_cnt[i] = 0; m_crc[i] = 16'hFFFF; m_words[i] = 0;
      m_hv[i] = 0; m_cn[i] = 0; m_sh[i] = 0; m_head[i] = 0;
    end else if (abort) begin
      m_st[i] = 0; m_hv[i] = 0; m_cn[i] = 0; m_sh[i] = 0; m_head[i] = 0;
    end else begin
      if (m_sh[i]) begin
        m_cnt[i]++;
        m_crc[i] = crc_ref(m_crc[i], tail);
      end
      if (m_st[i] != 1) begin
        if (start) begin
          m_st[i] = 1; m_cnt[i] = 0; m_crc[i] = 16'hFFFF;
          m_hv[i] = 0; m_cn[i] = 0; m_words[i] = 0;
        end
        m_sh[i] = 0; m_head[i] = 0;
      end else if (m_sh[i] && m_cnt[i] == f_cl(i)) begin
        m_st[i] = 2; m_sh[i] = 0; m_head[i] = 0;
      end else begin
        if (m_cn[i] > 0) begin
          m_head[i] = m_cd[i][7 - m_cp[i]]; m_cp[i]++; m_cn[i]--; m_sh[i] = 1;
        end else if (m_hv[i]) begin
          m_cd[i] = m_hd[i]; m_head[i] = m_cd[i][7]; m_cp[i] = 1;
          m_cn[i] = m_hn[i] - 1; m_sh[i] = 1; m_hv[i] = 0;
        end else begin
          m_sh[i] = 0; m_head[i] = 0;
        end
        if (acc) begin
          m_hv[i] = 1; m_hd[i] = data;
          m_hn[i] = (m_words[i] == f_nw(i) - 1) ? lastn : WW;
          m_words[i]++;
        end
      end
    end
  endtask

  task automatic check_all(input int i);
    chk($sformatf("d%0d_ready", i), 32'(i == 0 ? rdy0 : rdy1), 32'(m_ready(i)));
    chk($sformatf("d%0d_shift_en", i), 32'(i == 0 ? sh0 : sh1), 32'(m_sh[i]));
    chk($sformatf("d%0d_head", i), 32'(i == 0 ? head0 : head1), 32'(m_head[i]));
    chk($sformatf("d%0d_busy", i), 32'(i == 0 ? busy0 : busy1), 32'(m_st[i] == 1));
    chk($sformatf("d%0d_done", i), 32'(i == 0 ? done0 : done1), 32'(m_st[i] == 2));
    chk($sformatf("d%0d_bit_count", i), 32'(i == 0 ? bc0 : bc1), 32'(m_cnt[i]));
    chk($sformatf("d%0d_crc", i), 32'(i == 0 ? crc0 : crc1), 32'(m_crc[i]));
  endtask

  int   t = 0;
  bit   tail_rand = 1'b1;
  logic [31:0] rec0, rec1;
  int   nsh0, nsh1, first0, last0, done_t0;

  task automatic clr_rec();
    rec0 = '0; rec1 = '0; nsh0 = 0; nsh1 = 0; first0 = -1; last0 = -1; done_t0 = -1;
  endtask

  task automatic tick();
    if (tail_rand) tail = 1'($urandom_range(0, 1));
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
    t++;
    check_all(0);
    check_all(1);
    if (sh0) begin
      rec0 = {rec0[30:0], head0}; nsh0++;
      if (first0 < 0) first0 = t;
      last0 = t;
    end
    if (sh1) begin
      rec1 = {rec1[30:0], head1}; nsh1++;
    end
    if (done0 && done_t0 < 0) done_t0 = t;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit acc;
    acc = 1'b0;
    data = w; valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = m_ready(0);
      tick();
    end
    valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ready"}, 32'(rdy0), 32'(0));
    chk({p, "_shift_en"}, 32'(sh0), 32'(0));
    chk({p, "_head"}, 32'(head0), 32'(0));
    chk({p, "_busy"}, 32'(busy0), 32'(0));
    chk({p, "_done"}, 32'(done0), 32'(0));
    chk({p, "_bit_count"}, 32'(bc0), 32'(0));
    chk({p, "_crc"}, 32'(crc0), 32'hFFFF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; tail = 1'b0; data = '0;
    clr_rec();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("reset");

    // Back-to-back words into a chain of zeros.
    tail_rand = 1'b0; tail = 1'b0;
    clr_rec();
    pulse_start();
    send_word(8'hA5);
    send_word(8'h3C);
    repeat (20) tick();
    chk("p1_seq", 32'(rec0[15:0]), 32'h0000A53C);
    chk("p1_nshift", 32'(nsh0), 32'(16));
    chk("p1_gapfree", 32'(last0 - first0 + 1), 32'(16));
    chk("p1_done_next", 32'(done_t0), 32'(last0 + 1));
    chk("p1_bit_count", 32'(bc0), 32'(16));
    chk("p1_crc_zero", 32'(crc0), 32'h1D0F);
    chk("p1_seq12", 32'(rec1[11:0]), 32'h00000A53);
    tail_rand = 1'b1;

    // Partial last word on the 12-bit chain.
    clr_rec();
    pulse_start();
    send_word(8'hFF);
    send_word(8'hF0);
    repeat (18) tick();
    chk("p2_seq12", 32'(rec1[11:0]), 32'h00000FFF);
    chk("p2_nshift12", 32'(nsh1), 32'(12));
    chk("p2_shift_en_low", 32'(sh1), 32'(0));
    chk("p2_ready_low", 32'(rdy1), 32'(0));
    chk("p2_done12", 32'(done1), 32'(1));

    // Starvation between words.
    clr_rec();
    pulse_start();
    send_word(8'h96);
    repeat (14) tick();
    chk("p3_starve_shift_en", 32'(sh0), 32'(0));
    chk("p3_starve_busy", 32'(busy0), 32'(1));
    chk("p3_first_word_bits", 32'(nsh0), 32'(8));
    send_word(8'h69);
    chk("p3_latency0", 32'(sh0), 32'(0));
    tick();
    chk("p3_latency1", 32'(sh0), 32'(1));
    repeat (12) tick();
    chk("p3_total_shifts", 32'(nsh0), 32'(16));
    chk("p3_seq", 32'(rec0[15:0]), 32'h00009669);

    // Abort after five bits.
    pulse_start();
    valid = 1'b1;
    for (int k = 0; k < 40 && m_cnt[0] != 5; k++) begin
      data = 8'($urandom);
      tick();
    end
    chk("p4_bc_before", 32'(bc0), 32'(5));
    abort = 1'b1;
    tick();
    abort = 1'b0; valid = 1'b0;
    chk("p4_bc_frozen", 32'(bc0), 32'(5));
    chk("p4_shift_en", 32'(sh0), 32'(0));
    chk("p4_done", 32'(done0), 32'(0));
    chk("p4_busy", 32'(busy0), 32'(0));
    repeat (3) tick();
    chk("p4_bc_hold", 32'(bc0), 32'(5));
    pulse_start();
    chk("p4_restart_bc", 32'(bc0), 32'(0));
    chk("p4_restart_crc", 32'(crc0), 32'hFFFF);

    // Reset mid-load, then start from DONE with cfg_valid held high.
    valid = 1'b1;
    repeat (4) begin data = 8'($urandom); tick(); end
    rst = 1'b1; tick(); rst = 1'b0; valid = 1'b0;
    chk_reset_vals("p5_reset");
    pulse_start();
    valid = 1'b1;
    repeat (25) begin data = 8'($urandom); tick(); end
    chk("p5_done", 32'(done0), 32'(1));
    start = 1'b1; tick(); start = 1'b0;
    chk("p5_restart_bc", 32'(bc0), 32'(0));
    chk("p5_restart_crc", 32'(crc0), 32'hFFFF);
    chk("p5_restart_shift_en", 32'(sh0), 32'(0));
    tick();
    chk("p5_accept_cycle", 32'(sh0), 32'(0));
    tick();
    chk("p5_first_bit", 32'(sh0), 32'(1));
    valid = 1'b0;

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 99) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      valid = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the IO/logic tile ccff chain.
- Accepts parallel bitstream words from the host over a valid/ready interface and serializes them MSB-first onto ccff_head.
- Drives ccff_shift_en, which qualifies every prog_clk edge that shifts the chain.
- Monitors ccff_tail while loading and accumulates a CRC-16 of the previous chain contents, so the host gets a readback signature.

Parameters:
- CHAIN_LEN, 16, total configuration bits in the downstream chain; range 1..65535.
- WORD_W, 8, width of cfg_data.
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  input  1  synchronous abort; returns the block to IDLE.
- cfg_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  the block can accept a word.
- ccff_head  output  1  serial data into the chain.
- ccff_shift_en  output  1  the chain shifts on the next prog_clk edge.
- ccff_tail  input  1  serial data out of the chain.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- bit_count  output  CNT_W  bits shifted so far in the current load.
- crc_out  output  16  CRC-16 over the ccff_tail bits shifted out.

Behaviour:
- Clocking and reset: one clock, prog_clk. Reset pReset is synchronous and active-high.
- Reset values: state=IDLE; cfg_ready, ccff_head, ccff_shift_en, busy, done = 0; bit_count=0; crc_out=0xFFFF; holding buffer and shift register empty.
- States: IDLE, LOAD, DONE.
  - IDLE/DONE -> LOAD on start: clear bit_count to 0, set crc_out to 0xFFFF, empty both buffers, clear done.
  - start while in LOAD is ignored.
- Datapath: one-word holding buffer (hbuf) feeding a WORD_W shift register (sreg).
  - cfg_ready = LOAD and hbuf empty and words accepted < ceil(CHAIN_LEN/WORD_W). Combinational from registered state only; it never depends on cfg_valid.
  - A word is accepted on an edge where cfg_valid & cfg_ready; it enters hbuf.
  - sreg reloads from hbuf on an edge where sreg is empty, or is emitting its last valid bit. This gives gap-free streaming when the host keeps hbuf full.
- Output timing: ccff_head and ccff_shift_en are registered.
  - For each bit: ccff_shift_en=1 and ccff_head=bit during one cycle; the chain consumes the bit at the end of that cycle.
  - First-bit latency: word accepted at edge k -> first bit visible after edge k+1 (1-cycle latency).
- Starvation: if sreg and hbuf are both empty mid-load, ccff_shift_en=0 and ccff_head holds 0. The state stays LOAD, no error is raised, and shifting resumes on the next word.
- Counting and CRC: on every edge with ccff_shift_en=1:
  - bit_count increments.
  - CRC is updated with the current ccff_tail: fb = crc[15]^ccff_tail; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- Partial last word: when CHAIN_LEN mod WORD_W = r ≠ 0, only the top r bits of the final word are shifted; the remaining bits are discarded.
- Completion: on the edge where bit_count reaches CHAIN_LEN, go to DONE.
  - ccff_shift_en=0 from the next cycle; done=1, busy=0.
  - crc_out and bit_count hold until the next start or reset.
- Abort: abort in any state -> IDLE next edge.
  - ccff_shift_en deasserts immediately at that edge; buffers empty; done=0.
  - bit_count and crc_out freeze at their current values for debug.
  - abort has priority over start and over a same-cycle word acceptance.
- Reset mid-load: same as the reset values above. The downstream chain content is undefined and a full reload is required.
- Simultaneous events: reload of sreg from hbuf and acceptance into hbuf on the same edge is legal; hbuf stays full.

Test Plan:
- CHAIN_LEN=16, WORD_W=8: start, then present 0xA5 and 0x3C back-to-back with cfg_valid held high -> ccff_head sequence 1010010100111100 over 16 consecutive ccff_shift_en cycles with no gap; done=1 the cycle after the 16th bit; bit_count=16.
- Chain pre-filled with zeros (ccff_tail=0 throughout) -> crc_out=0x1D0F at DONE.
- CHAIN_LEN=12: words 0xFF, 0xF0 -> exactly 12 shift cycles (twelve 1s); ccff_shift_en low afterwards; cfg_ready stays 0 once both words are accepted.
- Starvation: after the first word, hold cfg_valid=0 for 5 cycles -> ccff_shift_en=0 for those cycles, busy=1; shifting resumes 1 cycle after the second word is accepted; total shifts=16.
- abort asserted after 5 bits -> state IDLE, ccff_shift_en=0 next cycle, bit_count=5 frozen, done=0; a new start clears bit_count to 0 and crc_out to 0xFFFF.
- pReset during LOAD, then start issued in DONE while cfg_valid=1 -> all outputs return to reset values; the new load restarts cleanly and the first bit appears 1 cycle after acceptance.
